calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 3, meaning the maximum digits accepted per operand.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum cycles to wait for the multiplier's mult_done.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 key_valid  input  1  one-cycle pulse: key_code is valid this cycle.
REQ-006 key_code  input  4  key code: 0-9 digit, 0xA operand/commit, 0xB clear, 0xC sign toggle, 0xD equals; 0xE-0xF ignored.
REQ-007 mult_done  input  1  one-cycle pulse from the Booth multiplier: mult_product is valid.
REQ-008 mult_product  input  16  signed product from the multiplier.
REQ-009 enable_A / enable_B  output  1 each  level: storage currently loads operand A / B; never both high.
REQ-010 digit_we  output  1  one-cycle pulse: storage appends digit_val.
REQ-011 digit_val  output  4  digit forwarded to storage; valid when digit_we=1.
REQ-012 commit_op  output  1  one-cycle pulse: storage latches its temporary value into the enabled operand.
REQ-013 neg_A / neg_B  output  1 each  level: operand A / B is negative.
REQ-014 mult_start  output  1  one-cycle pulse: multiplier begins.
REQ-015 result  output  16  registered product for display.
REQ-016 result_valid  output  1  level: result holds a fresh product.
REQ-017 timeout_err  output  1  level: the multiplier failed to respond.
REQ-018 state_o  output  3  current state encoding, for debug.

Function
REQ-019 The FSM SHALL have states ENTER_A, ENTER_B, START, WAIT, SHOW; key events SHALL be acted on only in the cycle key_valid=1.
REQ-020 In ENTER_A / ENTER_B, a digit key SHALL drive digit_we=1 and digit_val=key_code in the next cycle, and SHALL increment the digit counter.
REQ-021 Digits arriving when the digit counter equals MAX_DIGITS SHALL be dropped with no digit_we.
REQ-022 In ENTER_A, 0xA SHALL pulse commit_op, clear the digit counter and move to ENTER_B; enable_A falls and enable_B rises in the same cycle.
REQ-023 In ENTER_B, 0xA or 0xD SHALL pulse commit_op and move to START.
REQ-024 Key 0xC SHALL toggle neg_A in ENTER_A and neg_B in ENTER_B; it is ignored in all other states.
REQ-025 START SHALL last exactly one cycle with mult_start=1, then move to WAIT with the timeout counter at 0.
REQ-026 WAIT: on mult_done, register mult_product into result, set result_valid=1 and move to SHOW; latency from the mult_done edge to result_valid SHALL be 1 cycle.
REQ-027 WAIT: when the counter reaches TIMEOUT_CYCLES-1 without mult_done, set timeout_err=1, leave result unchanged and move to SHOW.
REQ-028 If mult_done and the timeout coincide, mult_done SHALL win: result is captured and timeout_err stays 0.
REQ-029 SHOW SHALL hold result; any digit key SHALL start a new calculation: clear result_valid, timeout_err, neg_A and neg_B, enter ENTER_A, and forward the digit as in REQ-020.
REQ-030 Key 0xB in any state SHALL enter ENTER_A, clear the counters, neg_A, neg_B, result_valid and timeout_err, and pulse commit_op=0; it overrides any simultaneous mult_done.
REQ-031 mult_done outside WAIT SHALL be ignored.
REQ-032 Keys other than 0xB received during START or WAIT SHALL be ignored.

Reset
REQ-033 On rst=0, the block SHALL asynchronously enter ENTER_A with enable_A=1 and every other output 0, including result=16'h0000 and both counters at 0.
REQ-034 Reset mid-WAIT SHALL abandon the operation; a later mult_done SHALL be ignored per REQ-031.

Structure
REQ-035 Package calc_pkg SHALL hold the key-code constants, the state enumeration and the default of TIMEOUT_CYCLES, shared with number_storage and the keypad scanner.
REQ-036 The timeout counter SHALL be a sub-module wait_timer with ports clk, rst, clr, en and expired; all other logic SHALL stay in a single FSM.

Verification
REQ-037 Key sequence 1,2,A,3,D with mult_done after 5 cycles and product 36: digit_we pulses carry 1,2,3; commit_op pulses twice; mult_start pulses once; result=36 and result_valid=1 one cycle after mult_done.
REQ-038 Digits 9,9,9,9 in ENTER_A: exactly 3 digit_we pulses.
REQ-039 Keys C,5,A,C,C,4,D: neg_A=1 and neg_B=0 at START.
REQ-040 mult_done withheld: timeout_err=1 after exactly 64 cycles in WAIT, result unchanged, state_o=SHOW.
REQ-041 Key 0xB in the same cycle as mult_done: state returns to ENTER_A and result_valid stays 0.
REQ-042 rst asserted in WAIT and then mult_done pulsed: outputs hold their reset values.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: key codes, sequencer states,
// and the default multiplier timeout.
package calc_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_COMMIT    = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_SIGN      = 4'hC;
  localparam logic [3:0] KEY_EQUALS    = 4'hD;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Cycle counter bounding how long the sequencer waits for the multiplier;
// expired is high from the count that marks the last allowed cycle.
module wait_timer
  import calc_pkg::*;
#(
  parameter int unsigned CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count;

  // Saturates at the terminal count so expired stays asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(CYCLES - 1));

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer: gathers two signed operands into number storage,
// launches the Booth multiplier and captures its product for display.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS     = 3,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        mult_done,
  input  logic [15:0] mult_product,
  output logic        enable_A,
  output logic        enable_B,
  output logic        digit_we,
  output logic [3:0]  digit_val,
  output logic        commit_op,
  output logic        neg_A,
  output logic        neg_B,
  output logic        mult_start,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        timeout_err,
  output logic [2:0]  state_o
);

  localparam int unsigned DW = $clog2(MAX_DIGITS + 1);

  state_t        state, state_d;
  logic [DW-1:0] dcnt, dcnt_d;
  logic          neg_a_d, neg_b_d, digit_we_d, commit_d, rv_d, te_d;
  logic [3:0]    digit_val_d;
  logic [15:0]   result_d;
  logic          expired, is_dig;

  wait_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != WAIT),
    .en      (state == WAIT),
    .expired (expired)
  );

  assign is_dig  = key_valid && is_digit(key_code);
  assign state_o = state;

  // Next state and next registered outputs; clear overrides everything.
  always_comb begin
    state_d     = state;
    dcnt_d      = dcnt;
    neg_a_d     = neg_A;
    neg_b_d     = neg_B;
    result_d    = result;
    rv_d        = result_valid;
    te_d        = timeout_err;
    digit_we_d  = 1'b0;
    digit_val_d = digit_val;
    commit_d    = 1'b0;

    if (key_valid && key_code == KEY_CLEAR) begin
      state_d = ENTER_A;
      dcnt_d  = '0;
      neg_a_d = 1'b0;
      neg_b_d = 1'b0;
      rv_d    = 1'b0;
      te_d    = 1'b0;
    end else begin
      case (state)
        ENTER_A, ENTER_B: begin
          if (is_dig && dcnt < DW'(MAX_DIGITS)) begin
            digit_we_d  = 1'b1;
            digit_val_d = key_code;
            dcnt_d      = dcnt + DW'(1);
          end else if (key_valid && key_code == KEY_SIGN) begin
            if (state == ENTER_A) neg_a_d = ~neg_A;
            else                  neg_b_d = ~neg_B;
          end else if (key_valid && (key_code == KEY_COMMIT ||
                       (state == ENTER_B && key_code == KEY_EQUALS))) begin
            commit_d = 1'b1;
            dcnt_d   = '0;
            state_d  = (state == ENTER_A) ? ENTER_B : START;
          end
        end
        START: state_d = WAIT;
        WAIT: begin
          if (mult_done) begin
            result_d = mult_product;
            rv_d     = 1'b1;
            state_d  = SHOW;
          end else if (expired) begin
            te_d    = 1'b1;
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (is_dig) begin
            state_d     = ENTER_A;
            rv_d        = 1'b0;
            te_d        = 1'b0;
            neg_a_d     = 1'b0;
            neg_b_d     = 1'b0;
            digit_we_d  = 1'b1;
            digit_val_d = key_code;
            dcnt_d      = DW'(1);
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ENTER_A;
      dcnt         <= '0;
      enable_A     <= 1'b1;
      enable_B     <= 1'b0;
      digit_we     <= 1'b0;
      digit_val    <= 4'h0;
      commit_op    <= 1'b0;
      neg_A        <= 1'b0;
      neg_B        <= 1'b0;
      mult_start   <= 1'b0;
      result       <= 16'h0000;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      dcnt         <= dcnt_d;
      enable_A     <= (state_d == ENTER_A);
      enable_B     <= (state_d == ENTER_B);
      digit_we     <= digit_we_d;
      digit_val    <= digit_val_d;
      commit_op    <= commit_d;
      neg_A        <= neg_a_d;
      neg_B        <= neg_b_d;
      mult_start   <= (state_d == START);
      result       <= result_d;
      result_valid <= rv_d;
      timeout_err  <= te_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: operand entry, sign keys, multiply
// handshake, timeout, clear priority and reset during a multiply.
module tb_calc_sequencer;

  localparam logic [2:0] S_ENTER_A = 3'd0;
  localparam logic [2:0] S_ENTER_B = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_SHOW    = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        mult_done;
  logic [15:0] mult_product;
  logic        enable_A, enable_B, digit_we, commit_op, neg_A, neg_B;
  logic        mult_start, result_valid, timeout_err;
  logic [3:0]  digit_val;
  logic [15:0] result;
  logic [2:0]  state_o;

  int vectors    = 0;
  int miscompares = 0;
  int n_we = 0, n_commit = 0, n_start = 0;
  logic [3:0] we_vals[$];

  calc_sequencer dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .mult_done(mult_done), .mult_product(mult_product),
    .enable_A(enable_A), .enable_B(enable_B), .digit_we(digit_we),
    .digit_val(digit_val), .commit_op(commit_op), .neg_A(neg_A), .neg_B(neg_B),
    .mult_start(mult_start), .result(result), .result_valid(result_valid),
    .timeout_err(timeout_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (digit_we) begin
      n_we++;
      we_vals.push_back(digit_val);
    end
    if (commit_op)  n_commit++;
    if (mult_start) n_start++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  task automatic test_reset();
    rst = 1'b0; key_valid = 1'b0; key_code = 4'hF;
    mult_done = 1'b0; mult_product = 16'h0000;
    #12;
    vectors++;
    if ({enable_A, enable_B, digit_we, commit_op, neg_A, neg_B, mult_start,
         result_valid, timeout_err} !== 9'b1_0000_0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want %b", {enable_A, enable_B, digit_we, commit_op,
               neg_A, neg_B, mult_start, result_valid, timeout_err}, 9'b1_0000_0000);
    end
    vectors++;
    if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result: got %h want 0000", result); end
    vectors++;
    if (state_o !== S_ENTER_A) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", state_o, S_ENTER_A); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int qi = we_vals.size();
    int c0 = n_commit, s0 = n_start;
    press(4'h1); press(4'h2); press(4'hA);
    vectors++;
    if ({commit_op, enable_A, enable_B, state_o} !== {3'b101, S_ENTER_B}) begin
      miscompares++;
      $display("FAIL basic_commit_a: got %b want %b", {commit_op, enable_A, enable_B, state_o}, {3'b101, S_ENTER_B});
    end
    press(4'h3); press(4'hD);
    vectors++;
    if ({mult_start, enable_B, state_o} !== {2'b10, S_START}) begin
      miscompares++;
      $display("FAIL basic_start: got %b want %b", {mult_start, enable_B, state_o}, {2'b10, S_START});
    end
    tick();
    vectors++;
    if ({mult_start, state_o} !== {1'b0, S_WAIT}) begin
      miscompares++;
      $display("FAIL basic_wait: got %b want %b", {mult_start, state_o}, {1'b0, S_WAIT});
    end
    repeat (4) tick();
    mult_done = 1'b1; mult_product = 16'd36;
    tick();
    mult_done = 1'b0;
    vectors++;
    if ({result_valid, result, state_o} !== {1'b1, 16'd36, S_SHOW}) begin
      miscompares++;
      $display("FAIL basic_result: got rv=%b res=%0d st=%0d want rv=1 res=36 st=%0d",
               result_valid, result, state_o, S_SHOW);
    end
    tick();
    vectors++;
    if (we_vals.size() - qi != 3 || {we_vals[qi], we_vals[qi+1], we_vals[qi+2]} !== 12'h123) begin
      miscompares++;
      $display("FAIL basic_digits: got %0d pulses want 3 carrying 1,2,3", we_vals.size() - qi);
    end
    vectors++;
    if (n_commit - c0 != 2 || n_start - s0 != 1) begin
      miscompares++;
      $display("FAIL basic_pulses: got commit=%0d start=%0d want commit=2 start=1", n_commit - c0, n_start - s0);
    end
  endtask

  task automatic test_max_digits();
    int w0;
    press(4'hB);
    vectors++;
    if ({state_o, result_valid, commit_op} !== {S_ENTER_A, 2'b00}) begin
      miscompares++;
      $display("FAIL clear_from_show: got %b want %b", {state_o, result_valid, commit_op}, {S_ENTER_A, 2'b00});
    end
    w0 = n_we;
    repeat (4) press(4'h9);
    tick();
    vectors++;
    if (n_we - w0 != 3) begin miscompares++; $display("FAIL max_digits: got %0d pulses want 3", n_we - w0); end
  endtask

  task automatic test_sign();
    press(4'hB);
    press(4'hC); press(4'h5); press(4'hA); press(4'hC); press(4'hC); press(4'h4); press(4'hD);
    vectors++;
    if ({state_o, neg_A, neg_B} !== {S_START, 2'b10}) begin
      miscompares++;
      $display("FAIL sign_at_start: got %b want %b", {state_o, neg_A, neg_B}, {S_START, 2'b10});
    end
    tick();
    mult_done = 1'b1; mult_product = 16'hFFEC;
    tick();
    mult_done = 1'b0;
    press(4'hC);
    vectors++;
    if ({state_o, neg_A, result} !== {S_SHOW, 1'b1, 16'hFFEC}) begin
      miscompares++;
      $display("FAIL sign_show: got st=%0d negA=%b res=%h want st=%0d negA=1 res=ffec", state_o, neg_A, result, S_SHOW);
    end
    press(4'h7);
    vectors++;
    if ({state_o, neg_A, result_valid, digit_we, digit_val, enable_A} !== {S_ENTER_A, 3'b001, 4'h7, 1'b1}) begin
      miscompares++;
      $display("FAIL show_new_calc: got %b want %b", {state_o, neg_A, result_valid, digit_we, digit_val, enable_A},
               {S_ENTER_A, 3'b001, 4'h7, 1'b1});
    end
  endtask

  task automatic test_timeout();
    int w0;
    int bad_wait = 0;
    press(4'hA); press(4'hD);
    w0 = n_we;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) begin key_valid = 1'b1; key_code = 4'h5; end
      tick();
      key_valid = 1'b0;
      if (state_o !== S_WAIT || timeout_err !== 1'b0) bad_wait++;
    end
    vectors++;
    if (bad_wait != 0) begin miscompares++; $display("FAIL timeout_wait_len: got %0d off-WAIT samples want 0", bad_wait); end
    tick();
    vectors++;
    if ({timeout_err, result_valid, state_o, result} !== {2'b10, S_SHOW, 16'hFFEC}) begin
      miscompares++;
      $display("FAIL timeout_show: got te=%b rv=%b st=%0d res=%h want te=1 rv=0 st=%0d res=ffec",
               timeout_err, result_valid, state_o, result, S_SHOW);
    end
    vectors++;
    if (n_we - w0 != 0) begin miscompares++; $display("FAIL wait_key_ignored: got %0d pulses want 0", n_we - w0); end
    mult_done = 1'b1; mult_product = 16'h1234;
    tick();
    mult_done = 1'b0;
    vectors++;
    if ({result, result_valid} !== {16'hFFEC, 1'b0}) begin
      miscompares++;
      $display("FAIL done_outside_wait: got res=%h rv=%b want res=ffec rv=0", result, result_valid);
    end
  endtask

  task automatic test_clear_vs_done();
    press(4'hB);
    vectors++;
    if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL clear_timeout: got %b want 0", timeout_err); end
    press(4'h2); press(4'hA); press(4'h3); press(4'hD);
    tick(); tick();
    key_valid = 1'b1; key_code = 4'hB; mult_done = 1'b1; mult_product = 16'h0063;
    tick();
    key_valid = 1'b0; mult_done = 1'b0;
    vectors++;
    if ({state_o, result_valid, commit_op, enable_A, result} !== {S_ENTER_A, 3'b001, 16'hFFEC}) begin
      miscompares++;
      $display("FAIL clear_beats_done: got st=%0d rv=%b res=%h want st=%0d rv=0 res=ffec",
               state_o, result_valid, result, S_ENTER_A);
    end
  endtask

  task automatic test_tie();
    press(4'h1); press(4'hA); press(4'h1); press(4'hD);
    repeat (64) tick();
    mult_done = 1'b1; mult_product = 16'h0042;
    tick();
    mult_done = 1'b0;
    vectors++;
    if ({result_valid, timeout_err, result, state_o} !== {2'b10, 16'h0042, S_SHOW}) begin
      miscompares++;
      $display("FAIL done_timeout_tie: got rv=%b te=%b res=%h st=%0d want rv=1 te=0 res=0042 st=%0d",
               result_valid, timeout_err, result, state_o, S_SHOW);
    end
  endtask

  task automatic test_reset_in_wait();
    press(4'h1); press(4'hA); press(4'h1); press(4'hD);
    tick(); tick();
    rst = 1'b0;
    #2;
    vectors++;
    if ({state_o, enable_A, result, result_valid, mult_start} !== {S_ENTER_A, 1'b1, 16'h0000, 2'b00}) begin
      miscompares++;
      $display("FAIL async_reset: got st=%0d enA=%b res=%h want st=%0d enA=1 res=0000", state_o, enable_A, result, S_ENTER_A);
    end
    #2;
    rst = 1'b1;
    mult_done = 1'b1; mult_product = 16'h0077;
    tick();
    mult_done = 1'b0;
    tick();
    vectors++;
    if ({state_o, enable_A, enable_B, result, result_valid, timeout_err} !== {S_ENTER_A, 2'b10, 16'h0000, 2'b00}) begin
      miscompares++;
      $display("FAIL done_after_reset: got st=%0d res=%h rv=%b want st=%0d res=0000 rv=0", state_o, result, result_valid, S_ENTER_A);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_digits();
    test_sign();
    test_timeout();
    test_clear_vs_done();
    test_tie();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
